// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: shared CPU definitions -- exception codes and the fetch-controller state type.
package cpu_defs_pkg;

    localparam logic [4:0] EX_INT  = 5'h00;
    localparam logic [4:0] EX_ADEL = 5'h04;
    localparam logic [4:0] EX_ADES = 5'h05;
    localparam logic [4:0] EX_SYS  = 5'h08;
    localparam logic [4:0] EX_BP   = 5'h09;
    localparam logic [4:0] EX_RI   = 5'h0a;
    localparam logic [4:0] EX_OV   = 5'h0c;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, FULL} ifc_state_t;

    function automatic logic pc_misaligned(input logic [1:0] lo);
        return |lo;
    endfunction

endpackage

// File: rtl/ifc_out_buf.sv
// ifc_out_buf: one-entry pc/inst/ex holding register for the fetch stage output.
//  clk, rst_n         clock, asynchronous active-low reset
//  load               capture ld_pc/ld_inst/ld_ex and mark valid (wins over clear)
//  clear              empty the entry, all fields to 0
//  ld_pc/ld_inst/ld_ex  data to capture
//  valid/pc/inst/ex   buffered entry
module ifc_out_buf #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] ld_pc,
    input  logic [DATA_W-1:0] ld_inst,
    input  logic              ld_ex,
    output logic              valid,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] inst,
    output logic              ex
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pc    <= '0;
            inst  <= '0;
            ex    <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= ld_pc;
            inst  <= ld_inst;
            ex    <= ld_ex;
        end else if (clear) begin
            valid <= 1'b0;
            pc    <= '0;
            inst  <= '0;
            ex    <= 1'b0;
        end
    end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: IF-stage sequencer for a req/addr_ok/data_ok instruction bus, one request in flight.
//  clk, rst_n                 clock, asynchronous active-low reset
//  fetch_pc/valid/ready       next-PC handshake; ready means the PC was taken this cycle
//  flush                      kill everything in flight
//  out_valid/ready/pc/inst    buffered instruction toward ID
//  out_ex/excode/badvaddr     misaligned-fetch exception info
//  inst_req/addr/addr_ok      bus address phase
//  inst_rdata/data_ok         bus data phase
//  IFC_PERF_CNT_EN            adds perf_fetch_cnt (IF->ID handshakes) and perf_wait_cnt (cycles in ADDR/DATA)
module inst_fetch_ctrl
    import cpu_defs_pkg::*;
#(
    parameter int         ADDR_W      = 32,
    parameter int         DATA_W      = 32,
    parameter logic [4:0] EXCODE_ADEL = EX_ADEL
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] fetch_pc,
    input  logic              fetch_valid,
    output logic              fetch_ready,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_inst,
    output logic              out_ex,
    output logic [4:0]        out_excode,
    output logic [ADDR_W-1:0] out_badvaddr,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic [DATA_W-1:0] inst_rdata,
    input  logic              inst_data_ok
`ifdef IFC_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_wait_cnt
`endif
);

    ifc_state_t state, state_nx;
    logic discard, discard_nx;
    logic accept, misalign, load_mem, load_ex, clear;

    assign fetch_ready = ~flush & ~discard & ((state == IDLE) | ((state == FULL) & out_ready));
    assign accept      = fetch_valid & fetch_ready;
    assign misalign    = pc_misaligned(fetch_pc[1:0]);
    assign load_mem    = (state == DATA) & inst_data_ok & ~discard & ~flush;
    assign load_ex     = accept & misalign;
    // Consuming the entry empties it; a same-cycle misaligned reload takes precedence inside the buffer.
    assign clear       = flush | ((state == FULL) & out_ready);
    assign inst_req    = (state == ADDR);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? (misalign ? FULL : ADDR) : IDLE;
            ADDR:    state_nx = inst_addr_ok ? DATA : ADDR;
            DATA:    state_nx = inst_data_ok ? ((discard | flush) ? IDLE : FULL) : DATA;
            FULL:    state_nx = flush ? IDLE : accept ? (misalign ? FULL : ADDR) : out_ready ? IDLE : FULL;
            default: state_nx = IDLE;
        endcase
    end

    // A flushed request still owns the bus until its data returns; discard remembers to drop it.
    assign discard_nx = (state == ADDR) ? (discard | flush) :
                        (state == DATA) ? (~inst_data_ok & (discard | flush)) : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            discard   <= 1'b0;
            inst_addr <= '0;
        end else begin
            state   <= state_nx;
            discard <= discard_nx;
            if (accept & ~misalign)
                inst_addr <= fetch_pc;
        end
    end

    ifc_out_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load_mem | load_ex),
        .clear   (clear),
        .ld_pc   (load_ex ? fetch_pc : inst_addr),
        .ld_inst (load_ex ? '0 : inst_rdata),
        .ld_ex   (load_ex),
        .valid   (out_valid),
        .pc      (out_pc),
        .inst    (out_inst),
        .ex      (out_ex)
    );

    assign out_excode   = out_ex ? EXCODE_ADEL : 5'd0;
    assign out_badvaddr = out_ex ? out_pc : '0;

`ifdef IFC_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_wait_cnt  <= '0;
        end else begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'(out_valid & out_ready);
            perf_wait_cnt  <= perf_wait_cnt + 32'((state == ADDR) | (state == DATA));
        end
    end
`else
    // Performance counters not built.
`endif

endmodule
